// File: rtl/rv32i_regfile_mp_pkg.sv
// Shared defaults and types for the multi-port RV32I register file and its return-address stack.
package rv32i_regfile_mp_pkg;

    localparam int unsigned DEF_XLEN     = 32;
    localparam int unsigned DEF_REG_BITS = 5;
    localparam int unsigned DEF_NUM_READ = 2;
    localparam int unsigned DEF_RAS_BITS = 3;

    localparam logic [DEF_REG_BITS-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic empty;
        logic full;
        logic ovf;
        logic unf;
    } ras_flags_t;

    localparam ras_flags_t RAS_FLAGS_RST = '{empty: 1'b1, full: 1'b0, ovf: 1'b0, unf: 1'b0};

endpackage

// File: rtl/rv32i_regfile_mp_if.sv
// Decode/writeback/fetch-side signal bundle of the register file; master drives, slave is the register file.
interface rv32i_regfile_mp_if
    import rv32i_regfile_mp_pkg::*;
#(
    parameter int unsigned XLEN     = DEF_XLEN,
    parameter int unsigned REG_BITS = DEF_REG_BITS,
    parameter int unsigned NUM_READ = DEF_NUM_READ
);

    logic                         write;
    logic [REG_BITS-1:0]          rd_addr;
    logic [XLEN-1:0]              data;
    logic [NUM_READ*REG_BITS-1:0] rs_addr;
    logic [NUM_READ*XLEN-1:0]     rs_data;
    logic                         push_ras;
    logic                         pop_ras;
    logic [XLEN-1:0]              pc;
    logic [XLEN-1:0]              ras;
    logic                         ras_empty;
    logic                         ras_full;
    logic                         ras_ovf;
    logic                         ras_unf;

    modport master (
        output write, rd_addr, data, rs_addr, push_ras, pop_ras, pc,
        input  rs_data, ras, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  write, rd_addr, data, rs_addr, push_ras, pop_ras, pc,
        output rs_data, ras, ras_empty, ras_full, ras_ovf, ras_unf
    );

endinterface

// File: rtl/rv32i_regfile_mp_ras.sv
// Circular return-address stack: overwrites the oldest entry when full, registered top/flags outputs.
module rv32i_regfile_mp_ras
    import rv32i_regfile_mp_pkg::*;
#(
    parameter int unsigned XLEN     = DEF_XLEN,
    parameter int unsigned RAS_BITS = DEF_RAS_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] top,
    output ras_flags_t      flags
);

    localparam int unsigned RAS_DEPTH = 2 ** RAS_BITS;
    localparam int unsigned CNT_BITS  = RAS_BITS + 1;

    logic [XLEN-1:0]     entry [RAS_DEPTH];
    logic [RAS_BITS-1:0] sp, sp_n, wr_ptr;
    logic [CNT_BITS-1:0] count, count_n;
    logic                wr_en_c;
    logic                is_empty_c, is_full_c;
    logic [XLEN-1:0]     top_n;
    ras_flags_t          flags_n;

    assign is_empty_c = (count == '0);
    assign is_full_c  = (count == CNT_BITS'(RAS_DEPTH));

    // Push+pop on an empty stack degrades to a plain push.
    always_comb begin
        sp_n    = sp;
        count_n = count;
        wr_en_c = 1'b0;
        wr_ptr  = sp;
        top_n   = top;
        flags_n = '0;
        if (push && (!pop || is_empty_c)) begin
            sp_n    = sp + RAS_BITS'(1);
            wr_en_c = 1'b1;
            wr_ptr  = sp_n;
            top_n   = pc;
            if (is_full_c) flags_n.ovf = 1'b1;
            else           count_n     = count + CNT_BITS'(1);
        end else if (push && pop) begin
            wr_en_c = 1'b1;
            top_n   = pc;
        end else if (pop) begin
            if (is_empty_c) begin
                flags_n.unf = 1'b1;
            end else begin
                sp_n    = sp - RAS_BITS'(1);
                count_n = count - CNT_BITS'(1);
                top_n   = (count_n == '0) ? '0 : entry[sp_n];
            end
        end
        flags_n.empty = (count_n == '0);
        flags_n.full  = (count_n == CNT_BITS'(RAS_DEPTH));
    end

    // Entry storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en_c) entry[wr_ptr] <= pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
            top   <= '0;
            flags <= RAS_FLAGS_RST;
        end else begin
            sp    <= sp_n;
            count <= count_n;
            top   <= top_n;
            flags <= flags_n;
        end
    end

endmodule

// File: rtl/rv32i_regfile_mp.sv
// RV32I register file with NUM_READ registered read ports, written-scoreboard and integrated RAS.
// Define RV32I_REGFILE_BYPASS_EN for write-first read-during-write; default is read-first.
module rv32i_regfile_mp
    import rv32i_regfile_mp_pkg::*;
#(
    parameter int unsigned XLEN     = DEF_XLEN,
    parameter int unsigned REG_BITS = DEF_REG_BITS,
    parameter int unsigned NUM_READ = DEF_NUM_READ,
    parameter int unsigned RAS_BITS = DEF_RAS_BITS
) (
    input logic               clk,
    input logic               rst,
    rv32i_regfile_mp_if.slave bus
);

    localparam int unsigned REG_COUNT = 2 ** REG_BITS;

    logic [REG_COUNT-1:0] written;
    logic                 wr_en_c;
    logic [XLEN-1:0]      ras_top;
    ras_flags_t           ras_flags;

    assign wr_en_c = bus.write && (bus.rd_addr != REG_BITS'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          written <= '0;
        else if (wr_en_c) written[bus.rd_addr] <= 1'b1;
    end

    // One private copy of the array per read port keeps each copy single-read.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_port
        logic [XLEN-1:0]     mem [REG_COUNT];
        logic [REG_BITS-1:0] addr;
        logic [XLEN-1:0]     rdata;

        assign addr = bus.rs_addr[k*REG_BITS +: REG_BITS];

        always_ff @(posedge clk) begin
            if (wr_en_c) mem[bus.rd_addr] <= bus.data;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata <= '0;
`ifdef RV32I_REGFILE_BYPASS_EN
            end else if (wr_en_c && (bus.rd_addr == addr)) begin
                rdata <= bus.data;
`endif
            end else if ((addr == REG_BITS'(REG_ZERO)) || !written[addr]) begin
                rdata <= '0;
            end else begin
                rdata <= mem[addr];
            end
        end

        assign bus.rs_data[k*XLEN +: XLEN] = rdata;
    end

    rv32i_regfile_mp_ras #(
        .XLEN     (XLEN),
        .RAS_BITS (RAS_BITS)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.push_ras),
        .pop   (bus.pop_ras),
        .pc    (bus.pc),
        .top   (ras_top),
        .flags (ras_flags)
    );

    assign bus.ras       = ras_top;
    assign bus.ras_empty = ras_flags.empty;
    assign bus.ras_full  = ras_flags.full;
    assign bus.ras_ovf   = ras_flags.ovf;
    assign bus.ras_unf   = ras_flags.unf;

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// Scoreboard bench for rv32i_regfile_mp: directed stimulus queues expectations, a monitor checks them.
module tb_rv32i_regfile_mp;

    localparam int K_RS    = 0;
    localparam int K_RAS   = 1;
    localparam int K_EMPTY = 2;
    localparam int K_FULL  = 3;
    localparam int K_OVF   = 4;
    localparam int K_UNF   = 5;

`ifdef RV32I_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int          tgt;
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    event chk_now;

    rv32i_regfile_mp_if bus ();

    rv32i_regfile_mp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] actual(input int kind, input int port);
        case (kind)
            K_RS:    return bus.rs_data[port*32 +: 32];
            K_RAS:   return bus.ras;
            K_EMPTY: return {31'b0, bus.ras_empty};
            K_FULL:  return {31'b0, bus.ras_full};
            K_OVF:   return {31'b0, bus.ras_ovf};
            default: return {31'b0, bus.ras_unf};
        endcase
    endfunction

    // Monitor: at each falling edge (or on demand for async events) check every due expectation.
    initial begin
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clk or chk_now);
            while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
                e = exp_q.pop_front();
                a = actual(e.kind, e.port);
                checks++;
                if (a !== e.val) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, a, e.val, cyc);
                end
            end
        end
    end

    task automatic exp_next(input int kind, input int port, input logic [31:0] val, input string name);
        exp_q.push_back('{tgt: cyc + 1, kind: kind, port: port, val: val, name: name});
    endtask

    task automatic exp_now(input int kind, input int port, input logic [31:0] val, input string name);
        exp_q.push_back('{tgt: cyc, kind: kind, port: port, val: val, name: name});
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.write = en; bus.rd_addr = a; bus.data = d;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rs_addr = {a1, a0};
    endtask

    task automatic ras_op(input logic push, input logic pop, input logic [31:0] pc);
        bus.push_ras = push; bus.pop_ras = pop; bus.pc = pc;
    endtask

    task automatic exp_rs(input logic [31:0] v0, input logic [31:0] v1, input string name);
        exp_next(K_RS, 0, v0, {name, "_p0"});
        exp_next(K_RS, 1, v1, {name, "_p1"});
    endtask

    task automatic exp_ras(input logic [31:0] top, input logic empty, input logic full,
                           input logic ovf, input logic unf, input string name);
        exp_next(K_RAS,   0, top,           {name, "_top"});
        exp_next(K_EMPTY, 0, {31'b0, empty}, {name, "_empty"});
        exp_next(K_FULL,  0, {31'b0, full},  {name, "_full"});
        exp_next(K_OVF,   0, {31'b0, ovf},   {name, "_ovf"});
        exp_next(K_UNF,   0, {31'b0, unf},   {name, "_unf"});
    endtask

    initial begin
        logic [31:0] v;
        wr(1'b0, 5'd0, 32'h0);
        rd(5'd0, 5'd0);
        ras_op(1'b0, 1'b0, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        exp_now(K_RS, 0, 32'h0, "rst_rs_p0");
        exp_now(K_RS, 1, 32'h0, "rst_rs_p1");
        exp_now(K_RAS, 0, 32'h0, "rst_ras");
        exp_now(K_EMPTY, 0, 32'h1, "rst_empty");
        exp_now(K_FULL, 0, 32'h0, "rst_full");
        exp_now(K_OVF, 0, 32'h0, "rst_ovf");
        exp_now(K_UNF, 0, 32'h0, "rst_unf");
        ->chk_now;
        #1;
        rst = 1'b0;

        // Register file: scoreboard, x0, read-during-write.
        tick(); rd(5'd5, 5'd5);                  exp_rs(32'h0, 32'h0, "x5_unwritten");
        tick(); wr(1'b1, 5'd5, 32'hDEADBEEF); rd(5'd0, 5'd0); exp_rs(32'h0, 32'h0, "x0_during_wr");
        tick(); wr(1'b0, 5'd0, 32'h0); rd(5'd5, 5'd5); exp_rs(32'hDEADBEEF, 32'hDEADBEEF, "x5_written");
        tick(); wr(1'b1, 5'd0, 32'h12345678); rd(5'd5, 5'd0); exp_rs(32'hDEADBEEF, 32'h0, "x0_wr");
        tick(); wr(1'b0, 5'd0, 32'h0); rd(5'd0, 5'd0); exp_rs(32'h0, 32'h0, "x0_after_wr");
        tick(); wr(1'b1, 5'd7, 32'hAAAA0000); rd(5'd7, 5'd5);
        exp_rs(BYP ? 32'hAAAA0000 : 32'h0, 32'hDEADBEEF, "x7_rdw_first");
        tick(); wr(1'b1, 5'd7, 32'h00005555); rd(5'd7, 5'd7);
        v = BYP ? 32'h00005555 : 32'hAAAA0000;
        exp_rs(v, v, "x7_rdw_second");
        tick(); wr(1'b0, 5'd0, 32'h0);            exp_rs(32'h5555, 32'h5555, "x7_final");

        // RAS push/pop ordering and underflow.
        tick(); ras_op(1'b1, 1'b0, 32'h100); exp_ras(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, "push100");
        tick(); ras_op(1'b1, 1'b0, 32'h104); exp_ras(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, "push104");
        tick(); ras_op(1'b1, 1'b0, 32'h108); exp_ras(32'h108, 1'b0, 1'b0, 1'b0, 1'b0, "push108");
        tick(); ras_op(1'b0, 1'b1, 32'h0);   exp_ras(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, "pop1");
        tick();                              exp_ras(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, "pop2");
        tick();                              exp_ras(32'h0,   1'b1, 1'b0, 1'b0, 1'b0, "pop3");
        tick();                              exp_ras(32'h0,   1'b1, 1'b0, 1'b0, 1'b1, "pop_unf");
        tick(); ras_op(1'b0, 1'b0, 32'h0);   exp_ras(32'h0,   1'b1, 1'b0, 1'b0, 1'b0, "unf_clear");

        // Overflow: nine pushes into an eight-deep stack.
        for (int i = 0; i < 9; i++) begin
            tick(); ras_op(1'b1, 1'b0, 32'(i * 4));
            exp_ras(32'(i * 4), 1'b0, i >= 7, i == 8, 1'b0, $sformatf("ovf_push%0d", i));
        end
        tick(); ras_op(1'b0, 1'b1, 32'h0);
        exp_ras(32'h1C, 1'b0, 1'b0, 1'b0, 1'b0, "ovf_pop1");
        for (int j = 2; j <= 8; j++) begin
            tick();
            exp_ras(32'(32'h20 - 32'(4 * j)), j == 8, 1'b0, 1'b0, 1'b0, $sformatf("ovf_pop%0d", j));
        end

        // Replace-top, then async reset mid-stream.
        tick(); ras_op(1'b1, 1'b0, 32'h200); exp_ras(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, "push200");
        tick(); ras_op(1'b1, 1'b1, 32'h300); exp_ras(32'h300, 1'b0, 1'b0, 1'b0, 1'b0, "replace300");
        tick(); ras_op(1'b0, 1'b1, 32'h0);   exp_ras(32'h0,   1'b1, 1'b0, 1'b0, 1'b0, "pop_after_replace");
        tick(); ras_op(1'b1, 1'b0, 32'h400); rd(5'd5, 5'd7);
        exp_ras(32'h400, 1'b0, 1'b0, 1'b0, 1'b0, "push400");
        exp_rs(32'hDEADBEEF, 32'h5555, "pre_rst_read");
        tick(); ras_op(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_now(K_EMPTY, 0, 32'h1, "async_rst_empty");
        exp_now(K_RAS, 0, 32'h0, "async_rst_ras");
        exp_now(K_RS, 0, 32'h0, "async_rst_rs_p0");
        exp_now(K_RS, 1, 32'h0, "async_rst_rs_p1");
        ->chk_now;
        #1;
        tick(); rst = 1'b0; rd(5'd5, 5'd7); exp_rs(32'h0, 32'h0, "post_rst_scoreboard");

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_regfile_mp.md
Name: rv32i_regfile_mp

Overview:
- Next-generation RV32I integer register file for the pipelined core.
- N parametrised registered read ports; x0 hardwired to zero; a per-register "written" scoreboard so unwritten registers read as zero after reset.
- Integrated circular return-address stack (RAS) with full/empty status and overflow/underflow pulses.
- Sits between decode (read addresses) and writeback (write port); the RAS is driven by fetch/branch logic.

Parameters:
- XLEN, 32, data width.
- REG_BITS, 5, register address width; REG_COUNT = 2**REG_BITS.
- NUM_READ, 2, number of read ports (1..4).
- RAS_BITS, 3, RAS address width; RAS_DEPTH = 2**RAS_BITS.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- write_i  in  1  write strobe.
- rd_addr_i  in  REG_BITS  write address.
- data_i  in  XLEN  write data.
- rs_addr_i  in  NUM_READ*REG_BITS  read addresses; port k occupies bits [k*REG_BITS +: REG_BITS].
- rs_data_o  out  NUM_READ*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- push_ras_i  in  1  push pc_i onto the RAS.
- pop_ras_i  in  1  pop the RAS.
- pc_i  in  XLEN  return address to push.
- ras_o  out  XLEN  current top of stack.
- ras_empty_o  out  1  stack count == 0.
- ras_full_o  out  1  stack count == RAS_DEPTH.
- ras_ovf_o  out  1  one-cycle pulse: push while full.
- ras_unf_o  out  1  one-cycle pulse: pop while empty.

Behaviour:
Reset values:
- On rst_i, all of the following clear asynchronously: rs_data_o=0, ras_o=0, ras_empty_o=1, ras_full_o=0, ras_ovf_o=0, ras_unf_o=0, scoreboard=0, sp=0, count=0.
- The storage arrays are not reset, so they remain BRAM/LUTRAM-inferable.

Write port:
- Storage is written when write_i=1 and rd_addr_i!=0; the same write sets scoreboard[rd_addr_i].
- A write with rd_addr_i==0 is ignored.

Read ports:
- Each port has 1-cycle latency: the address is sampled at edge N and the data is valid after edge N.
- Port output is 0 if the address is 0 or the scoreboard bit is clear; otherwise it is the stored value.
- All ports are independent, and any number of ports may share an address.
- Read-during-write to the same address: see Optional Feature.

RAS:
- Circular buffer with a top pointer sp and an occupancy count (0..RAS_DEPTH). ras_o is registered and always equals the current top entry after the edge, or 0 when empty.
- Push only: sp=sp+1 mod RAS_DEPTH, entry[sp]=pc_i, count=min(count+1, RAS_DEPTH). If the stack was full, the oldest entry is overwritten, ras_ovf_o pulses, and count stays at RAS_DEPTH.
- Pop only: if count>0, sp=sp-1 mod RAS_DEPTH and count decrements; ras_o becomes the new top, or 0 if the stack is now empty. If count==0, the state is unchanged and ras_unf_o pulses.
- Push and pop together (tail call/replace): entry[sp]=pc_i and count is unchanged. If count==0 this behaves as a push and no unf pulse is raised.
- Reset mid-sequence empties the stack immediately; stored entries are unreachable until pushed again.

Optional Feature:
- Macro: RV32I_REGFILE_BYPASS_EN.
- Defined: a read port whose address equals rd_addr_i, while write_i=1 and rd_addr_i!=0 at the same edge, returns data_i (write-first). This removes the WB to ID hazard stall.
- Undefined: the same case returns the pre-write value, or 0 if the scoreboard bit was clear (read-first). The hazard unit must stall one cycle.

Decomposition:
- Shared package/header (rv32i_pkg): XLEN, REG_BITS, RAS_BITS defaults and the REG_ZERO constant.
- One natural sub-module, rv32i_ras, containing the RAS pointer/count logic, storage and flags.
- The read ports are a generate loop over replicated single-read arrays.

Test Plan:
- Reset, then read x5 on all ports without any prior write -> 0 on every port. Then write x5=0xDEADBEEF and read it next cycle -> 0xDEADBEEF on all ports.
- Write x0=0x12345678, then read x0 -> 0. The scoreboard bit for x0 is never set.
- Write x7=0xAAAA0000 while port0 reads x7 in the same cycle. With BYPASS_EN -> 0xAAAA0000. Without -> 0, or the old value on a second write of 0x5555 (still the old value).
- Push 0x100, 0x104, 0x108 then pop three times -> ras_o 0x108, 0x104, 0x100, then 0 with ras_empty_o=1. A fourth pop -> ras_unf_o one-cycle pulse and ras_o stays 0.
- With RAS_BITS=3, push 9 values 0x0..0x20 step 4 -> ras_ovf_o pulses on the 9th push and ras_full_o=1. Eight pops return 0x20 down to 0x4; 0x0 is lost.
- Push 0x200, then push and pop together with pc_i=0x300 -> ras_o=0x300 and count=1. Assert rst_i asynchronously mid-stream -> ras_empty_o=1 and rs_data_o=0 immediately, without waiting for a clock edge.
